sample_serializer_10x: RTL and testbench

SAMPLE_SERIALIZER_10X -- requirements
Module: sample_serializer_10x

---
 rtl/sample_serializer_10x.sv | 156 +++++++++++++++
 tb/tb_sample_serializer_10x.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_serializer_10x.sv
// sample_serializer_10x
//   Takes 10-sample frames from the interpolator and plays them out one
//   sample per output-rate strobe. It is double buffered: a shadow frame
//   is loaded from the inputs, and an active frame is being played out.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   clk_en_10x    one-cycle output-rate strobe
//   load          one-cycle frame-ready pulse; captures sample_y0..y9
//   sample_y0..9  interpolated frame; y0 is played first
//   flag_clear    clears the sticky overrun/underrun flags
//   sample_out    current serialized sample, held between strobes
//   sample_valid  one-cycle pulse when sample_out takes a new value
//   sample_index  frame position (0-9) of the value on sample_out
//   overrun       sticky: a pending shadow frame was overwritten
//   underrun      sticky: a strobe found no data after playout started
//
// state   | meaning
// IDLE    | nothing played since reset; empty strobes are not an error
// RUN     | playing the active frame, idx_q is the next element
// STARVED | active frame finished with no shadow frame ready
module sample_serializer_10x #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en_10x,
    input  logic             load,
    input  logic [WIDTH-1:0] sample_y0,
    input  logic [WIDTH-1:0] sample_y1,
    input  logic [WIDTH-1:0] sample_y2,
    input  logic [WIDTH-1:0] sample_y3,
    input  logic [WIDTH-1:0] sample_y4,
    input  logic [WIDTH-1:0] sample_y5,
    input  logic [WIDTH-1:0] sample_y6,
    input  logic [WIDTH-1:0] sample_y7,
    input  logic [WIDTH-1:0] sample_y8,
    input  logic [WIDTH-1:0] sample_y9,
    input  logic             flag_clear,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_valid,
    output logic [3:0]       sample_index,
    output logic             overrun,
    output logic             underrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STARVED = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shadow_q [10];
    logic [WIDTH-1:0] active_q [10];
    logic [WIDTH-1:0] frame_in [10];
    logic             shadow_full_q;
    logic [3:0]       idx_q;
    logic [WIDTH-1:0] sample_out_q;
    logic             sample_valid_q;
    logic [3:0]       sample_index_q;
    logic             overrun_q;
    logic             underrun_q;

    logic             consume;
    logic             overrun_set;
    logic             underrun_set;

    always_comb begin
        frame_in[0] = sample_y0;
        frame_in[1] = sample_y1;
        frame_in[2] = sample_y2;
        frame_in[3] = sample_y3;
        frame_in[4] = sample_y4;
        frame_in[5] = sample_y5;
        frame_in[6] = sample_y6;
        frame_in[7] = sample_y7;
        frame_in[8] = sample_y8;
        frame_in[9] = sample_y9;
    end

    // The shadow frame is taken either at the end of a running frame or by
    // the first strobe after IDLE/STARVED.
    assign consume      = clk_en_10x && shadow_full_q &&
                          ((state_q != RUN) || (idx_q == 4'd9));
    // A load coinciding with consumption is a clean hand-over, not a loss.
    assign overrun_set  = load && shadow_full_q && !consume;
    assign underrun_set = clk_en_10x && (state_q == STARVED) && !shadow_full_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= 4'd0;
            shadow_full_q  <= 1'b0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            sample_index_q <= 4'd0;
            overrun_q      <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;

            if (clk_en_10x) begin
                case (state_q)
                    RUN: begin
                        sample_out_q   <= active_q[idx_q];
                        sample_index_q <= idx_q;
                        sample_valid_q <= 1'b1;
                        if (idx_q != 4'd9) begin
                            idx_q <= idx_q + 4'd1;
                        end else if (shadow_full_q) begin
                            for (int i = 0; i < 10; i++) active_q[i] <= shadow_q[i];
                            idx_q <= 4'd0;
                        end else begin
                            state_q <= STARVED;
                        end
                    end
                    IDLE, STARVED: begin
                        // Element 0 goes out directly from the shadow so the
                        // restart costs no extra strobe.
                        if (shadow_full_q) begin
                            for (int i = 0; i < 10; i++) active_q[i] <= shadow_q[i];
                            sample_out_q   <= shadow_q[0];
                            sample_index_q <= 4'd0;
                            sample_valid_q <= 1'b1;
                            idx_q          <= 4'd1;
                            state_q        <= RUN;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end

            if (load) begin
                for (int i = 0; i < 10; i++) shadow_q[i] <= frame_in[i];
                shadow_full_q <= 1'b1;
            end else if (consume) begin
                shadow_full_q <= 1'b0;
            end

            if (overrun_set)     overrun_q <= 1'b1;
            else if (flag_clear) overrun_q <= 1'b0;

            if (underrun_set)    underrun_q <= 1'b1;
            else if (flag_clear) underrun_q <= 1'b0;
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign sample_index = sample_index_q;
    assign overrun      = overrun_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_sample_serializer_10x.sv
// Bench for sample_serializer_10x: expected {index, value} pairs are queued
// as frames are loaded and popped whenever the DUT pulses sample_valid.
module tb_sample_serializer_10x;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         clk_en_10x;
    logic         load;
    logic         flag_clear;
    logic [W-1:0] y [10];
    logic [W-1:0] sample_out;
    logic         sample_valid;
    logic [3:0]   sample_index;
    logic         overrun;
    logic         underrun;

    int           n_checks = 0;
    int           n_errors = 0;
    int           valid_cnt = 0;
    int           valid_base;
    logic [11:0]  exp_q [$];
    logic [11:0]  mon_e;

    always #5 clk = ~clk;

    sample_serializer_10x #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en_10x   (clk_en_10x),
        .load         (load),
        .sample_y0    (y[0]),
        .sample_y1    (y[1]),
        .sample_y2    (y[2]),
        .sample_y3    (y[3]),
        .sample_y4    (y[4]),
        .sample_y5    (y[5]),
        .sample_y6    (y[6]),
        .sample_y7    (y[7]),
        .sample_y8    (y[8]),
        .sample_y9    (y[9]),
        .flag_clear   (flag_clear),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_index (sample_index),
        .overrun      (overrun),
        .underrun     (underrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && sample_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_valid", 32'(sample_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("sample_out", 32'(sample_out), 32'(mon_e[7:0]));
                check_eq("sample_index", 32'(sample_index), 32'(mon_e[11:8]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input int base);
        for (int i = 0; i < 10; i++) y[i] = W'(base + i);
    endtask

    task automatic push_frame(input int base);
        for (int i = 0; i < 10; i++) exp_q.push_back({4'(i), 8'(base + i)});
    endtask

    task automatic do_load(input int base, input bit push);
        set_frame(base);
        if (push) push_frame(base);
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic strobe(input bit exp_valid);
        clk_en_10x = 1'b1;
        cyc();
        clk_en_10x = 1'b0;
        check_eq("valid_after_strobe", 32'(sample_valid), 32'(exp_valid));
        repeat (3) cyc();
    endtask

    task automatic pulse_clear();
        flag_clear = 1'b1;
        cyc();
        flag_clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clk_en_10x = 1'b0;
        load = 1'b0;
        flag_clear = 1'b0;
        set_frame(0);
        repeat (3) cyc();
        check_eq("rst_sample_out", 32'(sample_out), 32'd0);
        check_eq("rst_valid", 32'(sample_valid), 32'd0);
        check_eq("rst_index", 32'(sample_index), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);
        reset = 1'b0;
        cyc();

        // Startup: empty strobes in IDLE are silent and not an underrun.
        repeat (3) strobe(1'b0);
        check_eq("idle_sample_out", 32'(sample_out), 32'd0);
        check_eq("idle_underrun", 32'(underrun), 32'd0);
        check_eq("idle_valid_cnt", 32'(valid_cnt), 32'd0);

        // Starvation: one frame then 12 strobes.
        do_load(5, 1'b1);
        repeat (10) strobe(1'b1);
        check_eq("starve_underrun_s10", 32'(underrun), 32'd0);
        strobe(1'b0);
        check_eq("starve_underrun_s11", 32'(underrun), 32'd1);
        check_eq("starve_hold_out", 32'(sample_out), 32'd14);
        check_eq("starve_hold_index", 32'(sample_index), 32'd9);
        strobe(1'b0);
        pulse_clear();
        check_eq("underrun_cleared", 32'(underrun), 32'd0);

        // Steady state: 0..29 across three frames.
        valid_base = valid_cnt;
        do_load(0, 1'b1);
        for (int s = 0; s < 30; s++) begin
            strobe(1'b1);
            if ((s % 10) == 3 && s < 20) do_load(10 * (s / 10 + 1), 1'b1);
        end
        check_eq("steady_valid_cnt", 32'(valid_cnt - valid_base), 32'd30);
        check_eq("steady_overrun", 32'(overrun), 32'd0);
        check_eq("steady_underrun", 32'(underrun), 32'd0);

        // Overrun: A playing, B pending, C overwrites B.
        do_load(100, 1'b1);
        strobe(1'b1);
        do_load(200, 1'b0);
        check_eq("overrun_before", 32'(overrun), 32'd0);
        do_load(150, 1'b1);
        check_eq("overrun_set", 32'(overrun), 32'd1);
        pulse_clear();
        check_eq("overrun_cleared", 32'(overrun), 32'd0);
        repeat (19) strobe(1'b1);

        // Load coinciding with the idx 9 strobe.
        do_load(40, 1'b1);
        strobe(1'b1);
        do_load(60, 1'b1);
        repeat (8) strobe(1'b1);
        set_frame(80);
        load = 1'b1;
        clk_en_10x = 1'b1;
        cyc();
        load = 1'b0;
        clk_en_10x = 1'b0;
        check_eq("simul_valid", 32'(sample_valid), 32'd1);
        check_eq("simul_overrun", 32'(overrun), 32'd0);
        repeat (3) cyc();
        strobe(1'b1);
        // Overwrite of the retained frame together with flag_clear: set wins.
        set_frame(90);
        push_frame(90);
        load = 1'b1;
        flag_clear = 1'b1;
        cyc();
        load = 1'b0;
        flag_clear = 1'b0;
        check_eq("clear_vs_set", 32'(overrun), 32'd1);
        repeat (19) strobe(1'b1);

        // Reset mid-frame with a pending frame, load and strobe all asserted.
        do_load(50, 1'b1);
        repeat (4) strobe(1'b1);
        do_load(70, 1'b0);
        set_frame(33);
        reset = 1'b1;
        load = 1'b1;
        clk_en_10x = 1'b1;
        cyc();
        cyc();
        check_eq("mid_rst_sample_out", 32'(sample_out), 32'd0);
        check_eq("mid_rst_valid", 32'(sample_valid), 32'd0);
        check_eq("mid_rst_index", 32'(sample_index), 32'd0);
        check_eq("mid_rst_overrun", 32'(overrun), 32'd0);
        check_eq("mid_rst_underrun", 32'(underrun), 32'd0);
        reset = 1'b0;
        load = 1'b0;
        clk_en_10x = 1'b0;
        exp_q.delete();
        cyc();
        repeat (2) strobe(1'b0);
        check_eq("post_rst_out", 32'(sample_out), 32'd0);
        check_eq("post_rst_underrun", 32'(underrun), 32'd0);
        do_load(20, 1'b1);
        repeat (10) strobe(1'b1);

        repeat (5) cyc();
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
